// File: rtl/alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_pkg: shared constants and channel enumeration for the alarm    |
// | input-conditioning stage.                                             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package alarm_pkg;

  localparam int CLK_HZ           = 48_000_000;
  localparam int DEB_CYCLES_DEF   = 480_000;      // 10 ms
  localparam int LONG_CYCLES_DEF  = 96_000_000;   // 2 s

  typedef enum logic [1:0] {CH_CR, CH_SM, CH_SP, CH_SJ} ch_e;

  localparam int NUM_CH = 4;

endpackage
`default_nettype wire

// File: rtl/alarm_input_cond_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_input_cond_if: raw button/sensor pins and conditioned outputs. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface alarm_input_cond_if;

  logic cr_raw;
  logic sm_raw;
  logic sp_raw;
  logic sj_raw;
  logic cr;
  logic sm;
  logic sp;
  logic sj;
  logic any_sensor;
  logic cr_long;

  modport master (
    output cr_raw, sm_raw, sp_raw, sj_raw,
    input  cr, sm, sp, sj, any_sensor, cr_long
  );

  modport slave (
    input  cr_raw, sm_raw, sp_raw, sj_raw,
    output cr, sm, sp, sj, any_sensor, cr_long
  );

endinterface
`default_nettype wire

// File: rtl/alarm_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_debounce: 2-FF synchroniser followed by a stable-count         |
// | debouncer; emits the clean level and a one-cycle rising pulse.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alarm_debounce #(
  parameter int DEB_CYCLES = 480_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_async,
  output logic level,
  output logic rise
);

  localparam int                c_cnt_w   = $clog2(DEB_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);

  logic               r_s1;
  logic               r_s2;
  logic               r_stable;
  logic               r_rise;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1   <= din_async;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end else begin
        // rise registers alongside stable so both change on the same edge
        r_stable <= r_s2;
        r_rise   <= r_s2;
        r_cnt    <= '0;
      end
    end
  end

  assign level = r_stable;
  assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/alarm_input_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_input_cond: synchronise/debounce remote button and sensors,    |
// | optional long-press detect under ALARM_CR_LONGPRESS_EN.               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alarm_input_cond
  import alarm_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  alarm_input_cond_if.slave bus
);

  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_rise;
  logic              r_any;
  logic              w_unused_rise;

  assign w_raw[CH_CR] = bus.cr_raw;
  assign w_raw[CH_SM] = bus.sm_raw;
  assign w_raw[CH_SP] = bus.sp_raw;
  assign w_raw[CH_SJ] = bus.sj_raw;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    alarm_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk       (clk),
      .reset_n   (reset_n),
      .din_async (w_raw[g]),
      .level     (w_level[g]),
      .rise      (w_rise[g])
    );
  end

  // Only the button needs an edge; sensors are consumed as levels
  assign w_unused_rise = w_rise[CH_SM] ^ w_rise[CH_SP] ^ w_rise[CH_SJ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_any <= 1'b0;
    end else begin
      r_any <= w_level[CH_SM] | w_level[CH_SP] | w_level[CH_SJ];
    end
  end

  assign bus.cr         = w_rise[CH_CR];
  assign bus.sm         = w_level[CH_SM];
  assign bus.sp         = w_level[CH_SP];
  assign bus.sj         = w_level[CH_SJ];
  assign bus.any_sensor = r_any;

`ifdef ALARM_CR_LONGPRESS_EN
  localparam int               c_lc_w   = $clog2(LONG_CYCLES + 1);
  localparam logic [c_lc_w-1:0] c_lc_max = c_lc_w'(LONG_CYCLES);

  logic [c_lc_w-1:0] r_lc;
  logic              r_cr_long;

  // Saturates at LONG_CYCLES so a held button yields exactly one pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lc      <= '0;
      r_cr_long <= 1'b0;
    end else if (!w_level[CH_CR]) begin
      r_lc      <= '0;
      r_cr_long <= 1'b0;
    end else if (r_lc != c_lc_max) begin
      r_lc      <= r_lc + c_lc_w'(1);
      r_cr_long <= (r_lc == c_lc_max - c_lc_w'(1));
    end else begin
      r_cr_long <= 1'b0;
    end
  end

  assign bus.cr_long = r_cr_long;
`else
  localparam int c_unused_long = LONG_CYCLES;

  assign bus.cr_long = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_input_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alarm_input_cond: directed bench, DEB_CYCLES=4, LONG_CYCLES=20.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_alarm_input_cond;

  localparam int DEB  = 4;
  localparam int LONG = 20;
`ifdef ALARM_CR_LONGPRESS_EN
  localparam int c_long_exp = 1;
`else
  localparam int c_long_exp = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alarm_input_cond_if bus();

  alarm_input_cond #(
    .DEB_CYCLES  (DEB),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cr/cr_long pulses over n cycles and records the first cycle of each
  task automatic watch(input int n, output int cr_cnt, output int cr_idx,
                       output int lg_cnt, output int lg_idx);
    cr_cnt = 0; cr_idx = 0; lg_cnt = 0; lg_idx = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (bus.cr === 1'b1) begin
        cr_cnt++;
        if (cr_idx == 0) cr_idx = i;
      end
      if (bus.cr_long === 1'b1) begin
        lg_cnt++;
        if (lg_idx == 0) lg_idx = i;
      end
    end
  endtask

  task automatic set_raw(input logic v);
    bus.cr_raw = v; bus.sm_raw = v; bus.sp_raw = v; bus.sj_raw = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cc, ci, lc, li;
    logic seen;

    // 1: reset with all inputs high, then release
    reset_n = 1'b0;
    set_raw(1'b1);
    repeat (3) tick();
    check("rst_cr", bus.cr, 0);
    check("rst_sm", bus.sm, 0);
    check("rst_sp", bus.sp, 0);
    check("rst_sj", bus.sj, 0);
    check("rst_any", bus.any_sensor, 0);
    check("rst_long", bus.cr_long, 0);
    reset_n = 1'b1;
    repeat (5) tick();
    check("t1_sm_early", bus.sm, 0);
    tick();
    check("t1_sm", bus.sm, 1);
    check("t1_sp", bus.sp, 1);
    check("t1_sj", bus.sj, 1);
    check("t1_cr", bus.cr, 1);
    check("t1_any_lag", bus.any_sensor, 0);
    tick();
    check("t1_any", bus.any_sensor, 1);
    check("t1_cr_1cyc", bus.cr, 0);
    set_raw(1'b0);
    repeat (12) tick();
    check("t1_sm_clr", bus.sm, 0);
    check("t1_any_clr", bus.any_sensor, 0);

    // 2: 3-cycle glitch on motion is rejected
    bus.sm_raw = 1'b1;
    repeat (3) tick();
    bus.sm_raw = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | bus.sm | bus.any_sensor;
    end
    check("t2_glitch", seen, 0);

    // 3: bouncing press then hold, then release
    bus.cr_raw = 1'b1; tick();
    bus.cr_raw = 1'b0; tick();
    bus.cr_raw = 1'b1; tick();
    bus.cr_raw = 1'b0; tick();
    bus.cr_raw = 1'b1;
    watch(30, cc, ci, lc, li);
    check("t3_cr_cnt", cc, 1);
    check("t3_cr_pos", ci, 6);
    check("t3_long_cnt", lc, c_long_exp);
    bus.cr_raw = 1'b0;
    watch(15, cc, ci, lc, li);
    check("t3_release", cc, 0);

    // 4: door and window together
    bus.sp_raw = 1'b1; bus.sj_raw = 1'b1;
    repeat (5) tick();
    check("t4_sp_early", bus.sp, 0);
    tick();
    check("t4_sp", bus.sp, 1);
    check("t4_sj", bus.sj, 1);
    check("t4_any_lag", bus.any_sensor, 0);
    tick();
    check("t4_any", bus.any_sensor, 1);
    bus.sp_raw = 1'b0; bus.sj_raw = 1'b0;
    repeat (5) tick();
    check("t4_sp_hold", bus.sp, 1);
    tick();
    check("t4_sp_fall", bus.sp, 0);
    check("t4_sj_fall", bus.sj, 0);
    check("t4_any_fall_lag", bus.any_sensor, 1);
    tick();
    check("t4_any_fall", bus.any_sensor, 0);

    // 5: async reset while motion is asserted
    bus.sm_raw = 1'b1;
    repeat (6) tick();
    check("t5_sm", bus.sm, 1);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check("t5_sm_async", bus.sm, 0);
    check("t5_any_async", bus.any_sensor, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("t5_sm_early", bus.sm, 0);
    tick();
    check("t5_sm_requal", bus.sm, 1);
    bus.sm_raw = 1'b0;
    repeat (12) tick();

    // 6: long press, release, re-press
    for (int p = 0; p < 2; p++) begin
      bus.cr_raw = 1'b1;
      watch(40, cc, ci, lc, li);
      check("t6_cr_cnt", cc, 1);
      check("t6_cr_pos", ci, 6);
      check("t6_long_cnt", lc, c_long_exp);
      check("t6_long_pos", li, (c_long_exp != 0) ? 26 : 0);
      bus.cr_raw = 1'b0;
      watch(15, cc, ci, lc, li);
      check("t6_rel_cr", cc, 0);
      check("t6_rel_long", lc, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
